// File: rtl/dice_result_capture.sv
// dice_result_capture: waits for the roller outputs to settle after button release, captures the
// dice and presents sum/doubles/range flags on valid/ready. Optional accumulator: DICE_SCORE_TOTAL_EN.
module dice_result_capture #(
    parameter int unsigned DICE_MAX      = 6,
    parameter int unsigned BIT_WIDTH     = $clog2(DICE_MAX) + 1,
    parameter int unsigned NUM_DICE      = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SUM_WIDTH     = $clog2(NUM_DICE * DICE_MAX + 1),
    parameter int unsigned CNT_WIDTH     = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            button,
    input  logic [NUM_DICE*BIT_WIDTH-1:0]   dice_values,
    input  logic                            res_ready,
    output logic                            res_valid,
    output logic [NUM_DICE*BIT_WIDTH-1:0]   res_dice,
    output logic [SUM_WIDTH-1:0]            res_sum,
    output logic                            res_doubles,
    output logic                            res_range_err,
`ifdef DICE_SCORE_TOTAL_EN
    input  logic                            total_clr,
    output logic [SUM_WIDTH+CNT_WIDTH-1:0]  res_total,
`endif
    output logic [CNT_WIDTH-1:0]            roll_count
);

    localparam int unsigned DICE_W = NUM_DICE * BIT_WIDTH;
    localparam int unsigned SC_W   = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SC_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic                   res_valid_q, res_valid_d;
    logic [DICE_W-1:0]      res_dice_q, res_dice_d;
    logic [SUM_WIDTH-1:0]   res_sum_q, res_sum_d;
    logic                   res_doubles_q, res_doubles_d;
    logic                   res_range_err_q, res_range_err_d;
    logic [CNT_WIDTH-1:0]   roll_count_q, roll_count_d;

    logic                   accept;
    logic [BIT_WIDTH-1:0]   die;
    logic [SUM_WIDTH-1:0]   sum_c;
    logic                   dbl_c;
    logic                   err_c;

    // Sum and flags of the live dice bus, used only at the capture point.
    always_comb begin
        die   = '0;
        sum_c = '0;
        dbl_c = (NUM_DICE >= 2);
        err_c = 1'b0;
        for (int i = 0; i < NUM_DICE; i++) begin
            die   = dice_values[i*BIT_WIDTH +: BIT_WIDTH];
            sum_c = sum_c + SUM_WIDTH'(die);
            if (die == '0 || die > BIT_WIDTH'(DICE_MAX)) begin
                err_c = 1'b1;
            end
            if (die != dice_values[BIT_WIDTH-1:0]) begin
                dbl_c = 1'b0;
            end
        end
    end

    assign accept = res_valid_q && res_ready;

    always_comb begin
        state_d         = state_q;
        settle_cnt_d    = settle_cnt_q;
        res_valid_d     = res_valid_q;
        res_dice_d      = res_dice_q;
        res_sum_d       = res_sum_q;
        res_doubles_d   = res_doubles_q;
        res_range_err_d = res_range_err_q;
        roll_count_d    = roll_count_q;
        case (state_q)
            ST_IDLE: begin
                if (button) state_d = ST_ROLLING;
            end
            ST_ROLLING: begin
                if (!button) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SC_W'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                // A re-press while settling discards the roll in progress.
                if (button) begin
                    state_d = ST_ROLLING;
                end else if (settle_cnt_q == '0) begin
                    state_d         = ST_PRESENT;
                    res_valid_d     = 1'b1;
                    res_dice_d      = dice_values;
                    res_sum_d       = sum_c;
                    res_doubles_d   = dbl_c;
                    res_range_err_d = err_c;
                end else begin
                    settle_cnt_d = settle_cnt_q - SC_W'(1);
                end
            end
            ST_PRESENT: begin
                if (accept) begin
                    res_valid_d = 1'b0;
                    if (roll_count_q != '1) roll_count_d = roll_count_q + CNT_WIDTH'(1);
                    state_d = button ? ST_ROLLING : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            settle_cnt_q    <= '0;
            res_valid_q     <= 1'b0;
            res_dice_q      <= '0;
            res_sum_q       <= '0;
            res_doubles_q   <= 1'b0;
            res_range_err_q <= 1'b0;
            roll_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            settle_cnt_q    <= settle_cnt_d;
            res_valid_q     <= res_valid_d;
            res_dice_q      <= res_dice_d;
            res_sum_q       <= res_sum_d;
            res_doubles_q   <= res_doubles_d;
            res_range_err_q <= res_range_err_d;
            roll_count_q    <= roll_count_d;
        end
    end

    assign res_valid     = res_valid_q;
    assign res_dice      = res_dice_q;
    assign res_sum       = res_sum_q;
    assign res_doubles   = res_doubles_q;
    assign res_range_err = res_range_err_q;
    assign roll_count    = roll_count_q;

`ifdef DICE_SCORE_TOTAL_EN
    localparam int unsigned TOT_W = SUM_WIDTH + CNT_WIDTH;

    logic [TOT_W-1:0] total_q, total_d;
    logic [TOT_W:0]   total_sum;

    // Saturating running score; a clear wins over a coincident accept.
    always_comb begin
        total_sum = {1'b0, total_q} + (TOT_W + 1)'(res_sum_q);
        total_d   = total_q;
        if (total_clr) begin
            total_d = '0;
        end else if (accept) begin
            total_d = total_sum[TOT_W] ? '1 : total_sum[TOT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
        end else begin
            total_q <= total_d;
        end
    end

    assign res_total = total_q;
`endif

endmodule

// File: tb/tb_dice_result_capture.sv
// Randomized self-checking bench for dice_result_capture against a behavioural roll model.
// Build with +define+DICE_SCORE_TOTAL_EN to also check the running total.
module tb_dice_result_capture;

    localparam int unsigned DICE_MAX = 6;
    localparam int unsigned NUM_DICE = 2;
    localparam int unsigned BW       = 4;
    localparam int unsigned DW       = NUM_DICE * BW;
    localparam int unsigned SUM_W    = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned TOT_MAX  = (1 << (SUM_W + CNT_W)) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             button = 1'b0;
    logic [DW-1:0]    dice_values = '0;
    logic             res_ready = 1'b0;
    logic             res_valid;
    logic [DW-1:0]    res_dice;
    logic [SUM_W-1:0] res_sum;
    logic             res_doubles;
    logic             res_range_err;
    logic [CNT_W-1:0] roll_count;
`ifdef DICE_SCORE_TOTAL_EN
    logic                   total_clr = 1'b0;
    logic [SUM_W+CNT_W-1:0] res_total;
    int                     exp_total = 0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    dice_result_capture #(
        .DICE_MAX(DICE_MAX), .BIT_WIDTH(BW), .NUM_DICE(NUM_DICE),
        .SETTLE_CYCLES(2), .SUM_WIDTH(SUM_W), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .dice_values(dice_values),
        .res_ready(res_ready), .res_valid(res_valid), .res_dice(res_dice),
        .res_sum(res_sum), .res_doubles(res_doubles), .res_range_err(res_range_err),
`ifdef DICE_SCORE_TOTAL_EN
        .total_clr(total_clr), .res_total(res_total),
`endif
        .roll_count(roll_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result of a roll, straight from the dice-game rules.
    function automatic void ref_result(input logic [DW-1:0] d, output int s, output bit dbl,
                                       output bit err);
        int f;
        int first;
        s = 0; dbl = 1'b1; err = 1'b0;
        first = int'(d) % (1 << BW);
        for (int i = 0; i < int'(NUM_DICE); i++) begin
            f = (int'(d) >> (int'(BW) * i)) % (1 << BW);
            s += f;
            if (f < 1 || f > int'(DICE_MAX)) err = 1'b1;
            if (f != first) dbl = 1'b0;
        end
        s = s % (1 << SUM_W);
    endfunction

    task automatic do_roll(input logic [DW-1:0] d, input int press, input int abort_at,
                           input int bp, input bit pulse, input bit clr);
        int s;
        bit dbl;
        bit err;
        int lat;
        ref_result(d, s, dbl, err);
        button = 1'b1;
        repeat (press) begin
            dice_values = DW'($urandom);
            step();
        end
        dice_values = d;
        if (abort_at > 0) begin
            button = 1'b0;
            repeat (abort_at) begin
                step();
                chk("abort_settle_valid", 32'(res_valid), 32'd0);
            end
            button = 1'b1;
            step();
            step();
            chk("abort_rolling_valid", 32'(res_valid), 32'd0);
        end
        button = 1'b0;
        lat = 0;
        while (!res_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd3);
        chk("dice", 32'(res_dice), 32'(d));
        chk("sum", 32'(res_sum), 32'(s));
        chk("doubles", 32'(res_doubles), 32'(dbl));
        chk("range_err", 32'(res_range_err), 32'(err));
        chk("count_before_accept", 32'(roll_count), 32'(exp_count));
        if (bp > 0) begin
            res_ready = 1'b0;
            for (int k = 0; k < bp; k++) begin
                dice_values = DW'($urandom);
                button = pulse && (k == bp / 2);
                step();
            end
            button = 1'b0;
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_dice", 32'(res_dice), 32'(d));
            chk("bp_sum", 32'(res_sum), 32'(s));
            chk("bp_doubles", 32'(res_doubles), 32'(dbl));
            chk("bp_count", 32'(roll_count), 32'(exp_count));
        end
        res_ready = 1'b1;
`ifdef DICE_SCORE_TOTAL_EN
        total_clr = clr;
`endif
        step();
        res_ready = 1'b0;
        if (exp_count < (1 << CNT_W) - 1) exp_count++;
`ifdef DICE_SCORE_TOTAL_EN
        total_clr = 1'b0;
        if (clr) exp_total = 0;
        else exp_total = (exp_total + s > int'(TOT_MAX)) ? int'(TOT_MAX) : exp_total + s;
        chk("total", 32'(res_total), 32'(exp_total));
`else
        if (clr) exp_count = exp_count + 0;
`endif
        chk("accept_valid", 32'(res_valid), 32'd0);
        chk("count", 32'(roll_count), 32'(exp_count));
        chk("held_sum", 32'(res_sum), 32'(s));
        chk("held_dice", 32'(res_dice), 32'(d));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_sum"}, 32'(res_sum), 32'd0);
        chk({tag, "_dice"}, 32'(res_dice), 32'd0);
        chk({tag, "_count"}, 32'(roll_count), 32'd0);
        chk({tag, "_flags"}, 32'({res_doubles, res_range_err}), 32'd0);
`ifdef DICE_SCORE_TOTAL_EN
        chk({tag, "_total"}, 32'(res_total), 32'd0);
`endif
    endtask

    initial begin
        logic [DW-1:0] d;
        repeat (3) step();
        check_zero("reset");
        reset = 1'b1;
        repeat (5) step();
        check_zero("idle");

        do_roll(8'h35, 10, 0, 0, 1'b0, 1'b0);
        do_roll(8'h44, 3, 0, 20, 1'b1, 1'b0);
        do_roll(8'h26, 4, 1, 0, 1'b0, 1'b0);
        do_roll(8'h53, 2, 2, 3, 1'b0, 1'b0);
        do_roll(8'h70, 2, 0, 0, 1'b0, 1'b0);
        do_roll(8'h11, 1, 0, 0, 1'b0, 1'b1);
        do_roll(8'h35, 2, 0, 0, 1'b0, 1'b0);
        do_roll(8'h14, 2, 0, 1, 1'b1, 1'b0);
        do_roll(8'h66, 2, 0, 0, 1'b0, 1'b1);

        for (int r = 0; r < 255; r++) begin
            if ($urandom_range(0, 7) == 0) d = DW'($urandom);
            else d = {4'($urandom_range(1, 6)), 4'($urandom_range(1, 6))};
            do_roll(d, $urandom_range(1, 4),
                    ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        chk("saturated", 32'(roll_count), 32'hFF);

        // Reset during a presented result drops it immediately.
        button = 1'b1;
        dice_values = 8'h23;
        step();
        button = 1'b0;
        repeat (3) step();
        chk("pre_reset_valid", 32'(res_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        step();
        step();
        reset = 1'b1;
        exp_count = 0;
`ifdef DICE_SCORE_TOTAL_EN
        exp_total = 0;
`endif
        do_roll(8'h62, 2, 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
